// File: rtl/aes128_cipher_iter.sv
// Iterative AES-128 encryption core: one round per clock, round key fetched through rk_idx.
// Define AES_TWO_CYCLE_ROUND_EN to split each round into a SubBytes/ShiftRows phase and a MixColumns/AddRoundKey phase.
module aes128_cipher_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] plaintext,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext
);
    // Handshake: start/plaintext are taken on a rising edge where ready=1 (IDLE or DONE);
    // start while busy is dropped, and done pulses for one cycle with ciphertext valid until the next done.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] ct_q, ct_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] sb_out, sr_out, pre_mc, mc_out;
    logic         step_go;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (4 * c + row) -: 8] = s[127 - 8 * (4 * ((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            r[127 - 32 * c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        subByte u_sub_byte (
            .data_in  (state_q[127 - 32 * g -: 32]),
            .data_out (sb_out[127 - 32 * g -: 32])
        );
    end

    assign sr_out = shift_rows(sb_out);
    assign mc_out = mix_columns(pre_mc);

`ifdef AES_TWO_CYCLE_ROUND_EN
    logic         phase_q, phase_d;
    logic [127:0] mid_q, mid_d;

    // Phase 0 captures SubBytes+ShiftRows; phase 1 consumes it with the round key.
    assign pre_mc  = mid_q;
    assign step_go = phase_q;

    always_comb begin
        phase_d = 1'b0;
        mid_d   = mid_q;
        if (fsm_q == ST_ROUND || fsm_q == ST_FINAL) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                mid_d = sr_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            mid_q   <= '0;
        end else begin
            phase_q <= phase_d;
            mid_q   <= mid_d;
        end
    end
`else
    assign pre_mc  = sr_out;
    assign step_go = 1'b1;
`endif

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        ct_d    = ct_q;
        round_d = round_q;
        case (fsm_q)
            ST_IDLE, ST_DONE: begin
                fsm_d = ST_IDLE;
                if (start) begin
                    state_d = plaintext ^ rk;
                    round_d = 4'd1;
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (step_go) begin
                    state_d = mc_out ^ rk;
                    round_d = round_q + 4'd1;
                    if (round_q == 4'd9) begin
                        fsm_d = ST_FINAL;
                    end
                end
            end
            ST_FINAL: begin
                if (step_go) begin
                    ct_d    = pre_mc ^ rk;
                    round_d = 4'd0;
                    fsm_d   = ST_DONE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rk_idx = 4'd0;
        case (fsm_q)
            ST_ROUND: rk_idx = round_q;
            ST_FINAL: rk_idx = 4'd10;
            default:  rk_idx = 4'd0;
        endcase
    end

    assign ready      = (fsm_q == ST_IDLE) || (fsm_q == ST_DONE);
    assign busy       = (fsm_q == ST_ROUND) || (fsm_q == ST_FINAL);
    assign done       = (fsm_q == ST_DONE);
    assign ciphertext = ct_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            ct_q    <= '0;
            round_q <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            ct_q    <= ct_d;
            round_q <= round_d;
        end
    end
endmodule

// 32-bit AES S-box: four bytes substituted in parallel.
// Each byte is inverted in GF(2^8) as x^254, then passed through the FIPS-197 affine map.
module subByte (
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_byte
        assign data_out[31 - 8 * g -: 8] = sbox(data_in[31 - 8 * g -: 8]);
    end
endmodule

// File: tb/tb_aes128_cipher_iter.sv
// Bench for aes128_cipher_iter: known-answer table, back-to-back, ignored start, mid-run reset, random blocks.
// The bench plays the round-key mux; its reference model is a byte-array AES built from a generated S-box.
module tb_aes128_cipher_iter;
`ifdef AES_TWO_CYCLE_ROUND_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif
    localparam int LAT     = 10 * STEPS;
    localparam int TIMEOUT = 100;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] plaintext;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         ready;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;

    logic [127:0] rk_tbl [16];
    logic [7:0]   sbox_t [256];
    logic [3:0]   idx_log [$];
    logic [3:0]   exp_q [$];
    vec_t         vecs [3];
    int           n_checks;
    int           n_fail;

    aes128_cipher_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .plaintext  (plaintext),
        .rk_idx     (rk_idx),
        .rk         (rk),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext)
    );

    assign rk = rk_tbl[rk_idx];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box generated by walking the multiplicative group with generator 3 and its inverse.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        return {w[4 * n], w[4 * n + 1], w[4 * n + 2], w[4 * n + 3]};
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] k, res;
        k = round_key(key, 0);
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ k[127 - 8 * i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4 * c] = s[row + 4 * ((c + row) % 4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
                if (r < 10) begin
                    s[4 * c]     = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                    s[4 * c + 3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                end else begin
                    s[4 * c] = a0; s[4 * c + 1] = a1; s[4 * c + 2] = a2; s[4 * c + 3] = a3;
                end
            end
            k = round_key(key, r);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8 * i -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    task automatic load_key(input logic [127:0] key);
        for (int n = 0; n < 11; n++) rk_tbl[n] = round_key(key, n);
    endtask

    // Called at a negedge; returns 1 time unit after the accepting edge.
    task automatic start_block(input logic [127:0] key, input logic [127:0] pt);
        load_key(key);
        idx_log.delete();
        idx_log.push_back(rk_idx);
        start     = 1'b1;
        plaintext = pt;
        @(posedge clk);
        #1;
        start     = 1'b0;
        plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
        check("accept_busy", busy, 1);
        check("accept_ready", ready, 0);
    endtask

    // Returns at the negedge where done is seen; lat = rising edges after the accepting edge.
    task automatic wait_done(output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        while (!got) begin
            @(negedge clk);
            idx_log.push_back(rk_idx);
            if (done) got = 1'b1;
            else if (lat >= TIMEOUT) break;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        check("done_seen", done, 1);
    endtask

    task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] exp);
        int lat;
        start_block(key, pt);
        wait_done(lat);
        check({tag, "_ct"}, ciphertext, exp);
        check({tag, "_latency"}, lat, LAT);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_ct_held"}, ciphertext, exp);
    endtask

    initial begin
        int lat, k, dones, first_done;
        logic injected;
        logic [127:0] key_r, pt_r;

        n_checks = 0;
        n_fail   = 0;
        build_sbox();
        for (int i = 0; i < 16; i++) rk_tbl[i] = '0;
        vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    pt:  128'h00112233445566778899aabbccddeeff,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'h3243f6a8885a308d313198a2e0370734,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{key: 128'h0, pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        rst_n     = 1'b0;
        start     = 1'b0;
        plaintext = '0;
        #3;
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rk_idx", rk_idx, 0);
        check("reset_ct", ciphertext, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            check("model_kat", model_encrypt(vecs[v].key, vecs[v].pt), vecs[v].ct);
            run_block("kat", vecs[v].key, vecs[v].pt, vecs[v].ct);
            if (v == 1) begin
                // Expected index trace: idle 0, rounds 1..10 each held STEPS cycles, then 0 in DONE.
                exp_q.delete();
                exp_q.push_back(4'd0);
                for (int r = 1; r <= 10; r++)
                    for (int p = 0; p < STEPS; p++) exp_q.push_back(r[3:0]);
                exp_q.push_back(4'd0);
                check("rk_idx_trace_len", idx_log.size(), exp_q.size());
                for (int i = 0; i < exp_q.size() && i < idx_log.size(); i++)
                    check("rk_idx_trace", idx_log[i], exp_q[i]);
            end
        end

        // Back-to-back: start held in the DONE cycle of the all-zero block.
        start_block(vecs[2].key, vecs[2].pt);
        wait_done(lat);
        check("b2b_first_ct", ciphertext, vecs[2].ct);
        check("b2b_first_latency", lat, LAT);
        check("b2b_ready_in_done", ready, 1);
        start_block(vecs[0].key, vecs[0].pt);
        wait_done(lat);
        check("b2b_second_ct", ciphertext, vecs[0].ct);
        check("b2b_second_latency", lat, LAT);
        @(negedge clk);
        check("b2b_done_pulse", done, 0);

        // start pulsed during round 5 with a different block must be dropped.
        start_block(vecs[0].key, vecs[0].pt);
        injected   = 1'b0;
        dones      = 0;
        first_done = -1;
        for (int c = 0; c < LAT + 8; c++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (first_done < 0) first_done = c;
            end
            if (rk_idx == 4'd5 && !injected) begin
                injected  = 1'b1;
                start     = 1'b1;
                plaintext = 128'hdeadbeef_01234567_89abcdef_cafef00d;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        check("ignore_injected", injected, 1);
        check("ignore_done_count", dones, 1);
        check("ignore_latency", first_done, LAT);
        check("ignore_ct", ciphertext, vecs[0].ct);
        check("ignore_idle", ready, 1);

        // Reset asserted while round 6 is in progress.
        start_block(vecs[1].key, vecs[1].pt);
        k = 0;
        while (rk_idx != 4'd6 && k < TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        check("reached_round6", rk_idx, 6);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_rk_idx", rk_idx, 0);
        check("abort_ct", ciphertext, 0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_block("after_reset", vecs[0].key, vecs[0].pt, vecs[0].ct);

        // Random blocks against the reference model.
        for (int n = 0; n < 6; n++) begin
            key_r = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt_r  = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (n == 0) pt_r = '1;
            run_block("random", key_r, pt_r, model_encrypt(key_r, pt_r));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
